// File: rtl/unlock_pkg.sv
// Shared state encoding and constants for the safe unlock sequencer.
package unlock_pkg;
  typedef enum logic [1:0] {STAGE, WAIT_KEY, UNLOCK, LOCKOUT} state_t;

  localparam logic [3:0] DEFAULT_CANCEL_KEY = 4'hC;
  localparam logic [7:0] CLOSED_ANGLE       = 8'd0;
endpackage

// File: rtl/unlock_sequencer_key_event.sv
// Turns the debounced key level into single-cycle confirm/cancel pulses.
module key_event
  import unlock_pkg::*;
#(
  parameter logic [3:0] CANCEL_KEY = DEFAULT_CANCEL_KEY
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_num,
  output logic       confirm_evt,
  output logic       cancel_evt
);
  logic key_prev;
  logic key_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) key_prev <= 1'b0;
    else          key_prev <= key_valid;
  end

  assign key_hit     = key_valid && !key_prev;
  assign cancel_evt  = key_hit && (key_num == CANCEL_KEY);
  assign confirm_evt = key_hit && (key_num != CANCEL_KEY);
endmodule

// File: rtl/unlock_sequencer.sv
// Chains the authentication stages, handles keypad confirmation, servo, lockout and relock.
//   state    | meaning
//   STAGE    | stage idx enabled, waiting for its pass/fail
//   WAIT_KEY | stage idx passed, waiting for keypad confirm before idx+1
//   UNLOCK   | all stages passed, servo open
//   LOCKOUT  | too many consecutive failures, everything held off
module unlock_sequencer
  import unlock_pkg::*;
#(
  parameter int          NUM_STAGES     = 2,
  parameter int          MAX_FAILS      = 3,
  parameter int          RELOCK_CYCLES  = 30000,
  parameter int          LOCKOUT_CYCLES = 60000,
  parameter int          OPEN_ANGLE     = 135,
  parameter logic [3:0]  CANCEL_KEY     = DEFAULT_CANCEL_KEY
) (
  input  logic                                                   clk,
  input  logic                                                   reset_n,
  input  logic [NUM_STAGES-1:0]                                  stage_pass,
  input  logic [NUM_STAGES-1:0]                                  stage_fail,
  input  logic                                                   key_valid,
  input  logic [3:0]                                             key_num,
  output logic [NUM_STAGES-1:0]                                  stage_rst_n,
  output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] sel,
  output logic                                                   kp_main,
  output logic [7:0]                                             angle,
  output logic [NUM_STAGES:0]                                    indicator,
  output logic                                                   unlocked,
  output logic                                                   lockout
);
  localparam int SEL_W    = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam int TMR_SPAN = (RELOCK_CYCLES > LOCKOUT_CYCLES) ? RELOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TMR_W    = (TMR_SPAN > 2) ? $clog2(TMR_SPAN) : 1;
  localparam int FC_W     = $clog2(MAX_FAILS + 1);

  localparam logic [SEL_W-1:0]      LAST_IDX     = SEL_W'(NUM_STAGES - 1);
  localparam logic [TMR_W-1:0]      RELOCK_LAST  = TMR_W'(RELOCK_CYCLES - 1);
  localparam logic [TMR_W-1:0]      LOCKOUT_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [NUM_STAGES-1:0] STAGE0_EN    = NUM_STAGES'(1);
  localparam logic [NUM_STAGES:0]   IND_CLOSED   = {1'b1, {NUM_STAGES{1'b0}}};
  localparam logic [NUM_STAGES:0]   IND_OPEN     = {1'b0, {NUM_STAGES{1'b1}}};

  state_t           state;
  logic [SEL_W-1:0] idx;
  logic [TMR_W-1:0] timer;
  logic [FC_W-1:0]  fail_cnt;
  logic [FC_W:0]    fail_inc;
  logic             fail_limit;
  logic             stage_active;
  logic             confirm_evt;
  logic             cancel_evt;

  key_event #(.CANCEL_KEY(CANCEL_KEY)) u_key_event (
    .clk         (clk),
    .reset_n     (reset_n),
    .key_valid   (key_valid),
    .key_num     (key_num),
    .confirm_evt (confirm_evt),
    .cancel_evt  (cancel_evt)
  );

  // A stage's verdict only counts once its enable has actually been released.
  assign stage_active = stage_rst_n[idx];
  assign fail_inc     = {1'b0, fail_cnt} + (FC_W+1)'(1);
  assign fail_limit   = fail_inc >= (FC_W+1)'(MAX_FAILS);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= STAGE;
      idx         <= '0;
      stage_rst_n <= '0;
      sel         <= '0;
      kp_main     <= 1'b0;
      angle       <= CLOSED_ANGLE;
      indicator   <= IND_CLOSED;
      unlocked    <= 1'b0;
      lockout     <= 1'b0;
      fail_cnt    <= '0;
      timer       <= '0;
    end else begin
      if (timer != '1) timer <= timer + TMR_W'(1);
      case (state)
        STAGE: begin
          stage_rst_n <= STAGE0_EN << idx;
          sel         <= idx;
          kp_main     <= 1'b0;
          if (stage_active && stage_pass[idx]) begin
            indicator[idx] <= 1'b1;
            fail_cnt       <= '0;
            stage_rst_n    <= '0;
            kp_main        <= 1'b1;
            timer          <= '0;
            if (idx == LAST_IDX) begin
              state     <= UNLOCK;
              sel       <= LAST_IDX;
              angle     <= 8'(OPEN_ANGLE);
              unlocked  <= 1'b1;
              indicator <= IND_OPEN;
            end else begin
              state <= WAIT_KEY;
              sel   <= idx + SEL_W'(1);
            end
          end else if (stage_active && stage_fail[idx]) begin
            if (fail_cnt != '1) fail_cnt <= fail_inc[FC_W-1:0];
            stage_rst_n <= '0;
            idx         <= '0;
            sel         <= '0;
            indicator   <= IND_CLOSED;
            timer       <= '0;
            if (fail_limit) begin
              state   <= LOCKOUT;
              lockout <= 1'b1;
              kp_main <= 1'b1;
            end
          end
        end
        WAIT_KEY: begin
          if (confirm_evt) begin
            state       <= STAGE;
            idx         <= idx + SEL_W'(1);
            sel         <= idx + SEL_W'(1);
            kp_main     <= 1'b0;
            stage_rst_n <= STAGE0_EN << (idx + SEL_W'(1));
            timer       <= '0;
          end else if (cancel_evt || timer == RELOCK_LAST) begin
            state     <= STAGE;
            idx       <= '0;
            sel       <= '0;
            kp_main   <= 1'b0;
            indicator <= IND_CLOSED;
            timer     <= '0;
          end
        end
        UNLOCK: begin
          if (confirm_evt || (!cancel_evt && timer == RELOCK_LAST)) begin
            state     <= STAGE;
            idx       <= '0;
            sel       <= '0;
            kp_main   <= 1'b0;
            angle     <= CLOSED_ANGLE;
            unlocked  <= 1'b0;
            indicator <= IND_CLOSED;
            timer     <= '0;
          end else if (cancel_evt) begin
            timer <= '0;
          end
        end
        LOCKOUT: begin
          if (timer == LOCKOUT_LAST) begin
            state    <= STAGE;
            fail_cnt <= '0;
            lockout  <= 1'b0;
            kp_main  <= 1'b0;
            timer    <= '0;
          end
        end
        default: state <= STAGE;
      endcase
    end
  end
endmodule

// File: tb/tb_unlock_sequencer.sv
// Randomised and directed checks of unlock_sequencer against a phase-level model.
module tb_unlock_sequencer;
  localparam int NS = 3;
  localparam int MF = 2;
  localparam logic [3:0] CK = 4'hC;
  localparam logic [19:0] RESET_VEC = {3'b000, 2'b00, 1'b0, 8'd0, 4'b1000, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [NS-1:0] stage_pass = '0;
  logic [NS-1:0] stage_fail = '0;
  logic key_valid = 1'b0;
  logic [3:0] key_num = 4'h0;
  logic [NS-1:0] stage_rst_n;
  logic [1:0] sel;
  logic kp_main;
  logic [7:0] angle;
  logic [NS:0] indicator;
  logic unlocked;
  logic lockout;

  int tests = 0;
  int failed = 0;

  // model: phase 0 stage, 1 waiting for key, 2 unlocked, 3 locked out
  int m_phase, m_idx, m_fails;
  logic [NS-1:0] m_greens;

  logic watch_rst1 = 1'b0;
  logic saw_rst1 = 1'b0;

  unlock_sequencer #(
    .NUM_STAGES(NS), .MAX_FAILS(MF), .RELOCK_CYCLES(20), .LOCKOUT_CYCLES(10),
    .OPEN_ANGLE(135), .CANCEL_KEY(CK)
  ) dut (
    .clk(clk), .reset_n(reset_n), .stage_pass(stage_pass), .stage_fail(stage_fail),
    .key_valid(key_valid), .key_num(key_num), .stage_rst_n(stage_rst_n), .sel(sel),
    .kp_main(kp_main), .angle(angle), .indicator(indicator), .unlocked(unlocked),
    .lockout(lockout)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (watch_rst1 && stage_rst_n[1]) saw_rst1 = 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset(); m_phase = 0; m_idx = 0; m_greens = '0; m_fails = 0; endtask
  task automatic model_home(); m_phase = 0; m_idx = 0; m_greens = '0; endtask

  task automatic model_pass();
    m_greens[m_idx] = 1'b1;
    m_fails = 0;
    m_phase = (m_idx == NS - 1) ? 2 : 1;
  endtask

  task automatic model_fail();
    m_fails++;
    model_home();
    if (m_fails >= MF) m_phase = 3;
  endtask

  task automatic model_key(input logic [3:0] k);
    if (m_phase == 1) begin
      if (k == CK) model_home();
      else begin m_phase = 0; m_idx++; end
    end else if (m_phase == 2 && k != CK) model_home();
  endtask

  function automatic logic [19:0] exp_vec();
    logic [2:0] srn; logic [1:0] s; logic kp; logic [7:0] ang; logic [3:0] ind; logic u, l;
    srn = '0; s = '0; kp = 1'b1; ang = 8'd0; ind = {1'b1, m_greens}; u = 1'b0; l = 1'b0;
    case (m_phase)
      0: begin srn = 3'(1) << m_idx; s = 2'(m_idx); kp = 1'b0; end
      1: s = 2'(m_idx + 1);
      2: begin s = 2'(NS - 1); ang = 8'd135; ind = 4'b0111; u = 1'b1; end
      default: begin l = 1'b1; ind = 4'b1000; end
    endcase
    return {srn, s, kp, ang, ind, u, l};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {stage_rst_n, sel, kp_main, angle, indicator, unlocked, lockout};
  endfunction

  task automatic press(input logic [3:0] k);
    @(negedge clk); key_valid = 1'b1; key_num = k;
    @(negedge clk); key_valid = 1'b0;
    model_key(k);
  endtask

  // One-cycle pulse on the model's current stage once it is enabled.
  task automatic stage_hit(input logic p, input logic f);
    int n = 0;
    while (stage_rst_n[m_idx] !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    tests++;
    if (stage_rst_n !== (3'(1) << m_idx)) begin
      failed++;
      $display("FAIL stage_enable idx=%0d: got %b expected %b", m_idx, stage_rst_n, 3'(1) << m_idx);
    end
    stage_pass[m_idx] = p; stage_fail[m_idx] = f;
    @(negedge clk); stage_pass = '0; stage_fail = '0;
    if (p) model_pass(); else if (f) model_fail();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests++; if (obs_vec() !== RESET_VEC) begin failed++; $display("FAIL reset_hold: got %h expected %h", obs_vec(), RESET_VEC); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL reset_release: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_happy_path();
    logic [3:0] seq [3] = '{4'b1001, 4'b1011, 4'b0111};
    for (int k = 0; k < NS; k++) begin
      stage_hit(1'b1, 1'b0);
      tests++; if (indicator !== seq[k]) begin failed++; $display("FAIL happy_indicator%0d: got %b expected %b", k, indicator, seq[k]); end
      if (k < NS - 1) press((k == 0) ? 4'h5 : 4'h1);
      repeat (2) @(negedge clk);
      tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL happy_step%0d: got %h expected %h", k, obs_vec(), exp_vec()); end
    end
    tests++; if ({unlocked, angle} !== {1'b1, 8'd135}) begin failed++; $display("FAIL happy_open: got %b/%0d expected 1/135", unlocked, angle); end
    press(4'h9);
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL happy_relock_key: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_cancel_wait();
    saw_rst1 = 1'b0; watch_rst1 = 1'b1;
    stage_hit(1'b1, 1'b0);
    press(CK);
    repeat (3) @(negedge clk);
    watch_rst1 = 1'b0;
    tests++; if (indicator !== 4'b1000) begin failed++; $display("FAIL cancel_indicator: got %b expected 1000", indicator); end
    tests++; if (saw_rst1 !== 1'b0) begin failed++; $display("FAIL cancel_no_stage1: got %b expected 0", saw_rst1); end
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL cancel_state: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_auto_relock();
    int cnt;
    for (int r = 0; r < 2; r++) begin
      stage_hit(1'b1, 1'b0); press(4'h7); stage_hit(1'b1, 1'b0); press(4'h2); stage_hit(1'b1, 1'b0);
      cnt = 0;
      while (unlocked === 1'b1 && cnt < 80) begin
        cnt++;
        if (r == 1 && cnt == 15) begin key_valid = 1'b1; key_num = CK; end
        if (cnt == 16) key_valid = 1'b0;
        @(negedge clk);
      end
      model_home();
      tests++; if (cnt != ((r == 0) ? 20 : 35)) begin failed++; $display("FAIL relock_cycles%0d: got %0d expected %0d", r, cnt, (r == 0) ? 20 : 35); end
      tests++; if ({angle, indicator} !== {8'd0, 4'b1000}) begin failed++; $display("FAIL relock_outputs%0d: got %0d/%b expected 0/1000", r, angle, indicator); end
      repeat (2) @(negedge clk);
    end
  endtask

  task automatic test_pass_and_fail();
    stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    stage_hit(1'b1, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL both_pass_wins: got %h expected %h", obs_vec(), exp_vec()); end
    press(CK);
    repeat (2) @(negedge clk);
    stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (lockout !== 1'b0) begin failed++; $display("FAIL both_count_cleared: got lockout=%b expected 0", lockout); end
    stage_hit(1'b1, 1'b0); press(CK);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fail_lockout();
    int cnt;
    stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL first_fail: got %h expected %h", obs_vec(), exp_vec()); end
    stage_hit(1'b1, 1'b0); press(4'h3); stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (lockout !== 1'b0) begin failed++; $display("FAIL fail_after_pass: got lockout=%b expected 0", lockout); end
    stage_hit(1'b0, 1'b1);
    cnt = 0;
    while (lockout === 1'b1 && cnt < 40) begin cnt++; @(negedge clk); end
    tests++; if (cnt != 10) begin failed++; $display("FAIL lockout_cycles: got %0d expected 10", cnt); end
    m_phase = 0; m_fails = 0;
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL lockout_exit: got %h expected %h", obs_vec(), exp_vec()); end
    stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (lockout !== 1'b0) begin failed++; $display("FAIL exit_clears_count: got lockout=%b expected 0", lockout); end
    stage_hit(1'b1, 1'b0); press(CK);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    stage_hit(1'b1, 1'b0);
    @(negedge clk); #2 reset_n = 1'b0; key_valid = 1'b1; key_num = 4'h5;
    #1;
    tests++; if (obs_vec() !== RESET_VEC) begin failed++; $display("FAIL reset_mid_wait: got %h expected %h", obs_vec(), RESET_VEC); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    repeat (3) @(negedge clk);
    stage_hit(1'b1, 1'b0);
    repeat (4) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL held_key_no_event: got %h expected %h", obs_vec(), exp_vec()); end
    key_valid = 1'b0;
    press(CK);
    stage_hit(1'b0, 1'b1); stage_hit(1'b0, 1'b1);
    repeat (3) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL reach_lockout: got %h expected %h", obs_vec(), exp_vec()); end
    #2 reset_n = 1'b0;
    #1;
    tests++; if (obs_vec() !== RESET_VEC) begin failed++; $display("FAIL reset_mid_lockout: got %h expected %h", obs_vec(), RESET_VEC); end
    @(negedge clk); reset_n = 1'b1; model_reset();
    repeat (2) @(negedge clk);
    stage_hit(1'b0, 1'b1);
    repeat (2) @(negedge clk);
    tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL reset_clears_count: got %h expected %h", obs_vec(), exp_vec()); end
  endtask

  task automatic test_random();
    int r, n;
    logic [3:0] k;
    for (int step = 0; step < 60; step++) begin
      k = 4'($urandom_range(0, 14));
      if (k >= 4'hC) k = k + 4'h1;
      if ($urandom_range(0, 2) == 0) k = CK;
      case (m_phase)
        0: begin
          r = $urandom_range(0, 3);
          if (r == 0) stage_hit(1'b1, 1'b0);
          else if (r == 1) stage_hit(1'b0, 1'b1);
          else if (r == 2) stage_hit(1'b1, 1'b1);
          else press(k);
        end
        1, 2: press(k);
        default: begin
          n = 0;
          while (lockout === 1'b1 && n < 30) begin n++; @(negedge clk); end
          m_phase = 0; m_fails = 0;
        end
      endcase
      repeat (2) @(negedge clk);
      tests++; if (obs_vec() !== exp_vec()) begin failed++; $display("FAIL random_step%0d phase=%0d: got %h expected %h", step, m_phase, obs_vec(), exp_vec()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_happy_path();
    test_cancel_wait();
    test_auto_relock();
    test_pass_and_fail();
    test_fail_lockout();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
